coherence_bus_ctrl: RTL and testbench

//  Snoopy MESI bus controller between N_CACHES private L1 data caches and one shared memory port.

---
 rtl/coherence_pkg.sv | 35 +++
 rtl/rr_arbiter.sv | 35 +++
 rtl/coherence_bus_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_coherence_bus_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/coherence_pkg.sv
// Shared types for the snoopy MESI bus controller: end states, bus FSM
// states, statistics record and a saturating increment helper.
package coherence_pkg;

  localparam int BLOCK_SIZE = 2;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    INVALID   = 2'b00,
    SHARED    = 2'b01,
    EXCLUSIVE = 2'b10,
    MODIFIED  = 2'b11
  } cc_end_state;

  typedef enum logic [2:0] {
    BUS_IDLE,
    BUS_SNOOP,
    BUS_WB,
    BUS_XFER,
    BUS_MEMRD,
    BUS_DONE
  } bus_state_e;

  typedef struct packed {
    word_t to_i;
    word_t to_s;
    word_t to_e;
  } cache_coherence_statistics_t;

  function automatic word_t sat_inc(input word_t v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: picks the lowest requesting index strictly
// after last_grant, wrapping around, as a one-hot vector plus its index.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  // Two passes give the wrap: indices above last_grant first, then the rest.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!grant_any && req[i] && (i > int'(last_grant))) begin
        grant[i]  = 1'b1;
        grant_idx = IW'(i);
        grant_any = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!grant_any && req[i] && (i <= int'(last_grant))) begin
        grant[i]  = 1'b1;
        grant_idx = IW'(i);
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Snoopy MESI bus controller: one miss at a time, snoop -> WB/XFER/MEMRD -> DONE.
// Optional transition counters are built when COHERENCE_STATS_EN is defined.
module coherence_bus_ctrl #(
  parameter int N_CACHES   = 2,
  parameter int BLOCK_SIZE = coherence_pkg::BLOCK_SIZE
) (
  input  logic                             CLK,
  input  logic                             nRST,
  input  logic [N_CACHES-1:0]              req_valid,
  input  logic [N_CACHES-1:0]              req_write,
  input  logic [32*N_CACHES-1:0]           req_addr,
  output logic [N_CACHES-1:0]              snoop_req,
  output logic [31:0]                      snoop_addr,
  output logic [1:0]                       snoop_state,
  input  logic [N_CACHES-1:0]              snoop_busy,
  input  logic [N_CACHES-1:0]              snoop_hit,
  input  logic [N_CACHES-1:0]              snoop_dirty,
  input  logic [32*BLOCK_SIZE*N_CACHES-1:0] snoop_data,
  output logic [N_CACHES-1:0]              snoop_complete,
  output logic [N_CACHES-1:0]              resp_valid,
  output logic [1:0]                       resp_state,
  output logic [32*BLOCK_SIZE-1:0]         resp_data,
  output logic                             mem_ren,
  output logic                             mem_wen,
  output logic [31:0]                      mem_addr,
  output logic [32*BLOCK_SIZE-1:0]         mem_wdata,
  input  logic [32*BLOCK_SIZE-1:0]         mem_rdata,
  input  logic                             mem_ready
`ifdef COHERENCE_STATS_EN
  ,
  output logic [31:0]                      stat_to_i,
  output logic [31:0]                      stat_to_s,
  output logic [31:0]                      stat_to_e
`endif
);

  import coherence_pkg::*;

  localparam int BW = 32 * BLOCK_SIZE;
  localparam int IW = $clog2(N_CACHES);
  localparam logic [N_CACHES-1:0] ONE_HOT0 = {{(N_CACHES-1){1'b0}}, 1'b1};

  bus_state_e          state;
  logic [IW-1:0]       last_grant;
  logic [IW-1:0]       req_id;
  logic                req_wr;
  logic [N_CACHES-1:0] snoop_mask;
  logic [N_CACHES-1:0] captured;
  logic [N_CACHES-1:0] hit_r;
  logic [N_CACHES-1:0] dirty_r;
  logic [BW-1:0]       data_r   [N_CACHES];
  logic [BW-1:0]       eff_data [N_CACHES];
  logic [N_CACHES-1:0] eff_hit;
  logic [N_CACHES-1:0] eff_dirty;
  logic                all_seen;
  logic [BW-1:0]       sel_data;
  logic                sel_found;
  logic [N_CACHES-1:0] grant;
  logic [IW-1:0]       grant_idx;
  logic                grant_any;
  logic [31:0]         grant_addr;
  logic                grant_write;

  rr_arbiter #(.N(N_CACHES), .IW(IW)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_any  (grant_any)
  );

  always_comb begin
    grant_addr  = '0;
    grant_write = 1'b0;
    for (int i = 0; i < N_CACHES; i++) begin
      if (grant[i]) begin
        grant_addr  = req_addr[i*32 +: 32];
        grant_write = req_write[i];
      end
    end
  end

  // Merge already-captured snoop answers with this cycle's non-busy answers,
  // so the last answering cache can be decided on in the same cycle.
  always_comb begin
    eff_hit   = '0;
    eff_dirty = '0;
    all_seen  = 1'b1;
    for (int i = 0; i < N_CACHES; i++) begin
      eff_data[i] = captured[i] ? data_r[i] : snoop_data[i*BW +: BW];
      if (IW'(i) != req_id) begin
        if (captured[i]) begin
          eff_hit[i]   = hit_r[i];
          eff_dirty[i] = dirty_r[i];
        end else if (!snoop_busy[i]) begin
          eff_hit[i]   = snoop_hit[i];
          eff_dirty[i] = snoop_dirty[i];
        end else begin
          all_seen = 1'b0;
        end
      end
    end
  end

  // Dirty owner takes precedence over clean sharers; lowest index wins.
  always_comb begin
    sel_data  = '0;
    sel_found = 1'b0;
    for (int i = 0; i < N_CACHES; i++) begin
      if (!sel_found && eff_dirty[i]) begin
        sel_data  = eff_data[i];
        sel_found = 1'b1;
      end
    end
    for (int i = 0; i < N_CACHES; i++) begin
      if (!sel_found && eff_hit[i]) begin
        sel_data  = eff_data[i];
        sel_found = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state          <= BUS_IDLE;
      last_grant     <= '0;
      req_id         <= '0;
      req_wr         <= 1'b0;
      snoop_mask     <= '0;
      captured       <= '0;
      hit_r          <= '0;
      dirty_r        <= '0;
      for (int i = 0; i < N_CACHES; i++) data_r[i] <= '0;
      snoop_req      <= '0;
      snoop_addr     <= '0;
      snoop_state    <= INVALID;
      snoop_complete <= '0;
      resp_valid     <= '0;
      resp_state     <= INVALID;
      resp_data      <= '0;
      mem_ren        <= 1'b0;
      mem_wen        <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      snoop_complete <= '0;
      resp_valid     <= '0;
      unique case (state)
        BUS_IDLE: begin
          if (grant_any) begin
            req_id      <= grant_idx;
            req_wr      <= grant_write;
            snoop_mask  <= ~grant;
            snoop_req   <= ~grant;
            snoop_addr  <= grant_addr;
            mem_addr    <= grant_addr;
            snoop_state <= grant_write ? INVALID : SHARED;
            captured    <= '0;
            state       <= BUS_SNOOP;
          end
        end
        BUS_SNOOP: begin
          for (int i = 0; i < N_CACHES; i++) begin
            if ((IW'(i) != req_id) && !captured[i] && !snoop_busy[i]) begin
              captured[i] <= 1'b1;
              hit_r[i]    <= snoop_hit[i];
              dirty_r[i]  <= snoop_dirty[i];
              data_r[i]   <= snoop_data[i*BW +: BW];
            end
          end
          if (all_seen) begin
            snoop_req  <= '0;
            resp_state <= req_wr ? MODIFIED : ((|eff_hit) ? SHARED : EXCLUSIVE);
            if (|eff_dirty) begin
              mem_wen   <= 1'b1;
              mem_wdata <= sel_data;
              resp_data <= sel_data;
              state     <= BUS_WB;
            end else if ((|eff_hit) && !req_wr) begin
              resp_data <= sel_data;
              state     <= BUS_XFER;
            end else begin
              mem_ren <= 1'b1;
              state   <= BUS_MEMRD;
            end
          end
        end
        BUS_WB: begin
          if (mem_ready) begin
            mem_wen        <= 1'b0;
            resp_valid     <= ONE_HOT0 << req_id;
            snoop_complete <= snoop_mask;
            state          <= BUS_DONE;
          end
        end
        BUS_XFER: begin
          resp_valid     <= ONE_HOT0 << req_id;
          snoop_complete <= snoop_mask;
          state          <= BUS_DONE;
        end
        BUS_MEMRD: begin
          if (mem_ready) begin
            mem_ren        <= 1'b0;
            resp_data      <= mem_rdata;
            resp_valid     <= ONE_HOT0 << req_id;
            snoop_complete <= snoop_mask;
            state          <= BUS_DONE;
          end
        end
        BUS_DONE: begin
          last_grant <= req_id;
          state      <= BUS_IDLE;
        end
        default: state <= BUS_IDLE;
      endcase
    end
  end

`ifdef COHERENCE_STATS_EN
  cache_coherence_statistics_t stats;
  logic                        any_hit_r;

  // Counters bump once per transaction, in the DONE cycle.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stats     <= '0;
      any_hit_r <= 1'b0;
    end else begin
      if (state == BUS_SNOOP && all_seen) any_hit_r <= |eff_hit;
      if (state == BUS_DONE) begin
        if (req_wr && any_hit_r) stats.to_i <= sat_inc(stats.to_i);
        if (!req_wr && resp_state == SHARED) stats.to_s <= sat_inc(stats.to_s);
        if (!req_wr && resp_state == EXCLUSIVE) stats.to_e <= sat_inc(stats.to_e);
      end
    end
  end

  assign stat_to_i = stats.to_i;
  assign stat_to_s = stats.to_s;
  assign stat_to_e = stats.to_e;
`endif

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed self-checking bench for coherence_bus_ctrl (N_CACHES=2, BLOCK_SIZE=2);
// counter checks are compiled in when COHERENCE_STATS_EN is defined.
module tb_coherence_bus_ctrl;
  import coherence_pkg::*;

  localparam int N  = 2;
  localparam int BW = 64;

  logic            CLK = 1'b0;
  logic            nRST;
  logic [N-1:0]    req_valid, req_write;
  logic [32*N-1:0] req_addr;
  logic [N-1:0]    snoop_req;
  logic [31:0]     snoop_addr;
  logic [1:0]      snoop_state;
  logic [N-1:0]    snoop_busy, snoop_hit, snoop_dirty;
  logic [BW*N-1:0] snoop_data;
  logic [N-1:0]    snoop_complete, resp_valid;
  logic [1:0]      resp_state;
  logic [BW-1:0]   resp_data;
  logic            mem_ren, mem_wen;
  logic [31:0]     mem_addr;
  logic [BW-1:0]   mem_wdata, mem_rdata;
  logic            mem_ready;
`ifdef COHERENCE_STATS_EN
  logic [31:0]     stat_to_i, stat_to_s, stat_to_e;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  coherence_bus_ctrl #(.N_CACHES(N), .BLOCK_SIZE(2)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .snoop_req      (snoop_req),
    .snoop_addr     (snoop_addr),
    .snoop_state    (snoop_state),
    .snoop_busy     (snoop_busy),
    .snoop_hit      (snoop_hit),
    .snoop_dirty    (snoop_dirty),
    .snoop_data     (snoop_data),
    .snoop_complete (snoop_complete),
    .resp_valid     (resp_valid),
    .resp_state     (resp_state),
    .resp_data      (resp_data),
    .mem_ren        (mem_ren),
    .mem_wen        (mem_wen),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ready      (mem_ready)
`ifdef COHERENCE_STATS_EN
    ,
    .stat_to_i      (stat_to_i),
    .stat_to_s      (stat_to_s),
    .stat_to_e      (stat_to_e)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance at negedges until some resp_valid bit rises (bounded).
  task automatic waitResp(output int cycles, output logic saw_mem);
    cycles  = 0;
    saw_mem = 1'b0;
    while (resp_valid == '0 && cycles < 50) begin
      @(negedge CLK);
      cycles++;
      if (mem_ren || mem_wen) saw_mem = 1'b1;
    end
    checkOutput("resp_timeout", 64'(resp_valid != '0), 64'd1);
  endtask

  // Wait for a memory strobe, hold ready low for gap cycles, then complete it.
  // Returns at the negedge of the cycle following the mem_ready cycle.
  task automatic applyStimulus(input logic [63:0] rd, input int gap,
                               output logic [31:0] addr_seen, output logic [63:0] wdata_seen,
                               output logic was_write);
    int n;
    n = 0;
    while (!(mem_ren || mem_wen) && n < 50) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("mem_timeout", 64'(mem_ren || mem_wen), 64'd1);
    addr_seen  = mem_addr;
    wdata_seen = mem_wdata;
    was_write  = mem_wen;
    repeat (gap) @(negedge CLK);
    checkOutput("mem_strobe_held", 64'(mem_ren || mem_wen), 64'd1);
    mem_rdata = rd;
    mem_ready = 1'b1;
    @(negedge CLK);
    mem_ready = 1'b0;
  endtask

  initial begin
    int          cyc;
    int          n;
    logic        saw_mem;
    logic [31:0] a_seen;
    logic [63:0] wd_seen;
    logic        was_wr;
    logic [N-1:0] acc;
    logic [63:0] d;

    nRST = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0;
    snoop_busy = '0; snoop_hit = '0; snoop_dirty = '0; snoop_data = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("rst_resp_state", 64'(resp_state), 64'(INVALID));
    checkOutput("rst_snoop_req", 64'(snoop_req), 64'd0);
    checkOutput("rst_mem_strobes", 64'({mem_ren, mem_wen}), 64'd0);
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
    nRST = 1'b1;

    $display("[TB] step 1: cache0 read miss, memory fill");
    req_valid = 2'b01; req_write = 2'b00; req_addr = {32'h0, 32'h100};
    @(negedge CLK);
    checkOutput("t1_snoop_req", 64'(snoop_req), 64'(2'b10));
    checkOutput("t1_snoop_addr", 64'(snoop_addr), 64'h100);
    applyStimulus(64'h1111_2222_3333_4444, 2, a_seen, wd_seen, was_wr);
    checkOutput("t1_mem_addr", 64'(a_seen), 64'h100);
    checkOutput("t1_was_read", 64'(was_wr), 64'd0);
    checkOutput("t1_resp_valid", 64'(resp_valid), 64'(2'b01));
    checkOutput("t1_resp_state", 64'(resp_state), 64'(EXCLUSIVE));
    checkOutput("t1_resp_data", resp_data, 64'h1111_2222_3333_4444);
    checkOutput("t1_snoop_complete", 64'(snoop_complete), 64'(2'b10));
    req_valid = 2'b00;
    @(negedge CLK);
    checkOutput("t1_single_pulse", 64'({resp_valid, snoop_complete}), 64'd0);

    $display("[TB] step 2: cache1 read, cache0 clean hit -> transfer");
    req_valid = 2'b10; req_write = 2'b00; req_addr = {32'h100, 32'h0};
    snoop_hit = 2'b11; snoop_dirty = 2'b10;
    snoop_data = {64'hDEAD_DEAD_DEAD_DEAD, 64'hAAAA_0000_BBBB_0001};
    @(negedge CLK);
    checkOutput("t2_snoop_req", 64'(snoop_req), 64'(2'b01));
    checkOutput("t2_snoop_state", 64'(snoop_state), 64'(SHARED));
    waitResp(cyc, saw_mem);
    checkOutput("t2_latency", 64'(cyc), 64'd2);
    checkOutput("t2_no_mem", 64'(saw_mem), 64'd0);
    checkOutput("t2_resp_valid", 64'(resp_valid), 64'(2'b10));
    checkOutput("t2_resp_state", 64'(resp_state), 64'(SHARED));
    checkOutput("t2_resp_data", resp_data, 64'hAAAA_0000_BBBB_0001);
    checkOutput("t2_snoop_complete", 64'(snoop_complete), 64'(2'b01));
    req_valid = 2'b00;
    @(negedge CLK);

    $display("[TB] step 3: cache1 write, cache0 dirty -> writeback");
    req_valid = 2'b10; req_write = 2'b10; req_addr = {32'h100, 32'h0};
    snoop_hit = 2'b01; snoop_dirty = 2'b01;
    snoop_data = {64'h0, 64'hC0DE_0000_0000_00D1};
    @(negedge CLK);
    checkOutput("t3_snoop_state", 64'(snoop_state), 64'(INVALID));
    checkOutput("t3_snoop_req", 64'(snoop_req), 64'(2'b01));
    applyStimulus(64'h9999_9999_9999_9999, 1, a_seen, wd_seen, was_wr);
    checkOutput("t3_was_write", 64'(was_wr), 64'd1);
    checkOutput("t3_mem_addr", 64'(a_seen), 64'h100);
    checkOutput("t3_mem_wdata", wd_seen, 64'hC0DE_0000_0000_00D1);
    checkOutput("t3_resp_valid", 64'(resp_valid), 64'(2'b10));
    checkOutput("t3_resp_state", 64'(resp_state), 64'(MODIFIED));
    checkOutput("t3_resp_data", resp_data, 64'hC0DE_0000_0000_00D1);
    checkOutput("t3_snoop_complete", 64'(snoop_complete), 64'(2'b01));
    req_valid = 2'b00; req_write = 2'b00;
    @(negedge CLK);
    checkOutput("t3_complete_pulse", 64'(snoop_complete), 64'd0);
`ifdef COHERENCE_STATS_EN
    checkOutput("stat_to_e", 64'(stat_to_e), 64'd1);
    checkOutput("stat_to_s", 64'(stat_to_s), 64'd1);
    checkOutput("stat_to_i", 64'(stat_to_i), 64'd1);
`endif

    $display("[TB] step 4: cache0 busy for five snoop cycles");
    req_valid = 2'b10; req_addr = {32'h200, 32'h0};
    snoop_busy = 2'b01; snoop_hit = 2'b01; snoop_dirty = 2'b01;
    snoop_data = {64'h0, 64'hBAD0_BAD0_BAD0_BAD0};
    @(negedge CLK);
    repeat (4) @(negedge CLK);
    checkOutput("t4_still_snooping", 64'(snoop_req), 64'(2'b01));
    checkOutput("t4_no_mem_while_busy", 64'({mem_ren, mem_wen}), 64'd0);
    snoop_busy = 2'b00; snoop_dirty = 2'b00;
    snoop_data = {64'h0, 64'h6000_D000_6000_D000};
    @(negedge CLK);
    snoop_hit = 2'b00; snoop_dirty = 2'b01;
    snoop_data = {64'h0, 64'hBAD1_BAD1_BAD1_BAD1};
    waitResp(cyc, saw_mem);
    checkOutput("t4_latency", 64'(cyc), 64'd1);
    checkOutput("t4_no_mem", 64'(saw_mem), 64'd0);
    checkOutput("t4_resp_state", 64'(resp_state), 64'(SHARED));
    checkOutput("t4_resp_data", resp_data, 64'h6000_D000_6000_D000);
    req_valid = 2'b00; snoop_dirty = 2'b00;
    @(negedge CLK);

    $display("[TB] step 5: both caches requesting, round-robin, then reset mid-fill");
    req_valid = 2'b11; req_write = 2'b00; req_addr = {32'h340, 32'h300};
    for (int k = 0; k < 4; k++) begin
      d = 64'hA5A5_0000_0000_0000 | 64'(k);
      applyStimulus(d, 0, a_seen, wd_seen, was_wr);
      checkOutput("t5_grant", 64'(resp_valid), (k % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
      checkOutput("t5_addr", 64'(a_seen), (k % 2 == 0) ? 64'h300 : 64'h340);
      checkOutput("t5_data", resp_data, d);
    end
    n = 0;
    while (!mem_ren && n < 20) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("t5_mem_busy", 64'(mem_ren), 64'd1);
    nRST = 1'b0;
    @(negedge CLK);
    checkOutput("t5_rst_ren", 64'(mem_ren), 64'd0);
    checkOutput("t5_rst_pulses", 64'({resp_valid, snoop_complete, snoop_req}), 64'd0);
    checkOutput("t5_rst_state", 64'(resp_state), 64'(INVALID));
`ifdef COHERENCE_STATS_EN
    checkOutput("t5_rst_stat_e", 64'(stat_to_e), 64'd0);
`endif
    req_valid = 2'b00;
    @(negedge CLK);
    nRST = 1'b1;
    acc = '0;
    repeat (6) begin
      @(negedge CLK);
      acc = acc | resp_valid | snoop_complete;
    end
    checkOutput("t5_no_resp_after_abort", 64'(acc), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
